// File: rtl/weight_multiply.sv
// Weight-multiply stage of a dot-product lane: each activation is scaled by a
// per-position Q(W-F).F weight and the saturated product is forwarded on a stb/rdy stream.
module weight_multiply #(
    parameter int W = 16,
    parameter int F = 8,
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_stb,
    input  logic [$clog2(N)-1:0] w_adr,
    input  logic [W-1:0]         w_dat,
    input  logic                 s_stb,
    input  logic [W-1:0]         s_dat,
    output logic                 s_rdy,
    input  logic                 m_rdy,
    output logic                 m_stb,
    output logic [W-1:0]         m_dat
);

    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);

    logic signed [W-1:0]   weight [N];
    logic [AW-1:0]         idx;
    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] shifted;
    logic [W-1:0]          sat_val;
    logic                  xfer;

    assign s_rdy = ~m_stb | m_rdy;
    assign xfer  = s_stb & s_rdy;

    always_comb begin
        prod    = $signed(s_dat) * weight[idx];
        shifted = prod >>> F;
        sat_val = shifted[W-1:0];
        // The shifted product fits in W bits only if its top W+1 bits are all sign copies.
        if (!((&shifted[2*W-1:W-1]) || (~|shifted[2*W-1:W-1]))) begin
            if (shifted[2*W-1])
                sat_val = {1'b1, {(W-1){1'b0}}};
            else
                sat_val = {1'b0, {(W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_stb <= 1'b0;
            m_dat <= '0;
        end else if (xfer) begin
            m_stb <= 1'b1;
            m_dat <= sat_val;
        end else if (m_stb && m_rdy) begin
            m_stb <= 1'b0;
        end
    end

    // A cycle with no offered input ends the vector, so the next burst restarts at weight 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (xfer) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else if (!s_stb) begin
            idx <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++)
                weight[i] <= '0;
        end else if (w_stb && (int'(w_adr) < N)) begin
            weight[w_adr] <= w_dat;
        end
    end

endmodule

// File: tb/tb_weight_multiply.sv
// Directed self-checking bench for weight_multiply with hand-computed products.
module tb_weight_multiply;

    localparam int W = 16;
    localparam int F = 8;
    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         w_stb;
    logic [1:0]   w_adr;
    logic [W-1:0] w_dat;
    logic         s_stb;
    logic [W-1:0] s_dat;
    logic         s_rdy;
    logic         m_rdy;
    logic         m_stb;
    logic [W-1:0] m_dat;

    int checkCount;
    int errorCount;

    weight_multiply #(.W(W), .F(F), .N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .w_stb (w_stb),
        .w_adr (w_adr),
        .w_dat (w_dat),
        .s_stb (s_stb),
        .s_dat (s_dat),
        .s_rdy (s_rdy),
        .m_rdy (m_rdy),
        .m_stb (m_stb),
        .m_dat (m_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic stb, input logic [W-1:0] dat);
        s_stb = stb;
        s_dat = dat;
    endtask

    task automatic writeWeight(input logic [1:0] adr, input logic [W-1:0] dat);
        w_stb = 1'b1;
        w_adr = adr;
        w_dat = dat;
        tick();
        w_stb = 1'b0;
    endtask

    // One isolated beat: offered for one cycle, then a gap that drains the output.
    task automatic sendSingle(input string tag, input logic [W-1:0] dat, input logic [W-1:0] expected);
        applyStimulus(1'b1, dat);
        tick();
        applyStimulus(1'b0, '0);
        checkOutput({tag, "_stb"}, 32'(m_stb), 32'd1);
        checkOutput(tag, 32'(m_dat), 32'(expected));
        tick();
    endtask

    task automatic sendBurst(input string tag, input int len, input logic [W-1:0] dat,
                             input logic [W-1:0] expected [8]);
        for (int i = 0; i < len; i++) begin
            applyStimulus(1'b1, dat);
            tick();
            checkOutput({tag, "_stb"}, 32'(m_stb), 32'd1);
            checkOutput(tag, 32'(m_dat), 32'(expected[i]));
        end
        applyStimulus(1'b0, '0);
        tick();
        checkOutput({tag, "_gap"}, 32'(m_stb), 32'd0);
    endtask

    logic [W-1:0] expSeq [8];
    logic [W-1:0] bpExp [6];

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst   = 1'b0;
        w_stb = 1'b0;
        w_adr = '0;
        w_dat = '0;
        s_stb = 1'b0;
        s_dat = '0;
        m_rdy = 1'b1;

        #12;
        checkOutput("reset_stb", 32'(m_stb), 32'd0);
        checkOutput("reset_dat", 32'(m_dat), 32'd0);
        checkOutput("reset_rdy", 32'(s_rdy), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("release_stb", 32'(m_stb), 32'd0);

        // Basic 2.0 * 1.5
        writeWeight(2'd0, 16'h0200);
        applyStimulus(1'b1, 16'h0180);
        #1;
        checkOutput("basic_srdy", 32'(s_rdy), 32'd1);
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("basic_stb", 32'(m_stb), 32'd1);
        checkOutput("basic_dat", 32'(m_dat), 32'h0300);
        tick();
        checkOutput("basic_drop", 32'(m_stb), 32'd0);

        // Index sequencing and gap framing
        writeWeight(2'd0, 16'h0100);
        writeWeight(2'd1, 16'h0200);
        writeWeight(2'd2, 16'h0300);
        writeWeight(2'd3, 16'h0400);
        expSeq = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0100, 16'h0200, 16'h0300, 16'h0400};
        sendBurst("burst4", 4, 16'h0100, expSeq);
        sendSingle("after_gap4", 16'h0100, 16'h0100);
        sendBurst("burst2", 2, 16'h0100, expSeq);
        sendSingle("after_gap2", 16'h0100, 16'h0100);
        sendBurst("burst5", 5, 16'h0100, expSeq);

        // Saturation and sign handling on weight 0
        writeWeight(2'd0, 16'h0200);
        sendSingle("sat_pos", 16'h7F00, 16'h7FFF);
        sendSingle("sat_neg", 16'h8000, 16'h8000);
        writeWeight(2'd0, 16'h0080);
        sendSingle("neg_half", 16'hFF00, 16'hFF80);
        sendSingle("neg_trunc", 16'hFFFF, 16'hFFFF);
        writeWeight(2'd0, 16'hFF00);
        sendSingle("neg_weight", 16'h0300, 16'hFD00);

        // Backpressure: m_rdy low for cycles 2..4 of a 6-beat continuous burst
        writeWeight(2'd0, 16'h0100);
        bpExp = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0100, 16'h0200};
        begin
            int sent;
            int recv;
            sent = 0;
            recv = 0;
            for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
                applyStimulus(sent < 6, 16'h0100);
                m_rdy = !(cyc >= 2 && cyc <= 4);
                #3;
                if (sent > 0 && sent < 6)
                    checkOutput("bp_stb_held", 32'(m_stb), 32'd1);
                if (!m_rdy && m_stb) begin
                    checkOutput("bp_srdy", 32'(s_rdy), 32'd0);
                    checkOutput("bp_hold", 32'(m_dat), 32'(bpExp[recv]));
                end
                if (m_stb && m_rdy) begin
                    checkOutput("bp_dat", 32'(m_dat), 32'(bpExp[recv]));
                    recv++;
                end
                if (s_stb && s_rdy)
                    sent++;
                tick();
            end
            checkOutput("bp_recv", 32'(recv), 32'd6);
            checkOutput("bp_sent", 32'(sent), 32'd6);
        end
        m_rdy = 1'b1;
        applyStimulus(1'b0, '0);
        tick();
        checkOutput("bp_drain", 32'(m_stb), 32'd0);

        // Write collision: beat at idx 1 sees the old weight
        applyStimulus(1'b1, 16'h0100);
        tick();
        checkOutput("coll_b0", 32'(m_dat), 32'h0100);
        w_stb = 1'b1;
        w_adr = 2'd1;
        w_dat = 16'h0500;
        tick();
        w_stb = 1'b0;
        applyStimulus(1'b0, '0);
        checkOutput("coll_old", 32'(m_dat), 32'h0200);
        tick();
        expSeq[1] = 16'h0500;
        sendBurst("coll_new", 2, 16'h0100, expSeq);

        // Asynchronous reset mid-burst
        applyStimulus(1'b1, 16'h0100);
        tick();
        checkOutput("prerst_stb", 32'(m_stb), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_stb", 32'(m_stb), 32'd0);
        checkOutput("arst_dat", 32'(m_dat), 32'd0);
        applyStimulus(1'b0, '0);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("arst_release", 32'(m_stb), 32'd0);
        sendSingle("arst_zero_w", 16'h0100, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
